coin_dispenser: RTL and testbench
=================================

Name: coin_dispenser

Overview:
- Transmit side of the 2-bit coin-code interface: converts an amount, in half-unit steps, into a timed sequence of coin codes on D_out.
- Drives the same encoding the vending-machine FSM samples on D_in: 00 none, 01 half unit, 10 one unit, 11 reserved.
- Serves as the change/refund emitter and as a synthesizable stimulus source for the vending FSM.
- Greedy encoding: all one-unit coins first, then at most one half-unit coin.

Parameters:
- AW, 4, width of Amount in half-units; maximum amount is 2^AW-1.
- HOLD, 2, cycles each coin code is held on D_out; must be >= 1.
- GAP, 1, cycles of 00 after each coin; must be >= 1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Amount  input  AW  value to emit in half-units; sampled with Start.
- Abort  input  1  synchronous cancel; has priority over Start.
- D_out  output  2  coin code, registered.
- Busy  output  1  high while a sequence is in progress, registered.
- Done  output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (Reset=0, asynchronous): D_out=00, Busy=0, Done=0, state IDLE, Remaining=0, timer=0.
- States: IDLE, DRIVE (coin code held), GAP (00 held).
- Done defaults to 0 every cycle unless set below.
- IDLE with Start=1, Abort=0, and Amount!=0:
  - Remaining <= Amount minus the first coin value.
  - D_out <= 10 if Amount>=2, else 01.
  - Busy <= 1; state <= DRIVE; timer <= 0.
- IDLE with Start=1, Abort=0, and Amount==0: Done <= 1 on the next edge; Busy stays 0; no coin is emitted.
- DRIVE: hold the code for HOLD cycles in total. On the last of them: D_out <= 00; state <= GAP.
- GAP: hold 00 for GAP cycles. On the last of them:
  - If Remaining==0: Busy <= 0, Done <= 1, state <= IDLE.
  - Otherwise: emit the next coin (10 if Remaining>=2, else 01), subtract its value from Remaining, state <= DRIVE.
- Timing: with Start sampled at edge E0 and N coins, codes and gaps follow back to back. Done is high after edge E(N*(HOLD+GAP)). Busy is high after E0 through that edge, not inclusive.
- Coin count: N = floor(Amount/2) + (Amount mod 2).
- Code 11 is never driven.
- Start while Busy is ignored; Amount is not re-sampled.
- Start in the same cycle Done is high is accepted, because the state is already IDLE.
- Abort in any state: on the next edge D_out=00, Busy=0, Done=0, Remaining=0, state IDLE. No Done pulse is produced for an aborted sequence.
- Abort together with Start in IDLE: Start is ignored.
- Reset asserted mid-sequence: outputs clear immediately (asynchronously). After release the block waits in IDLE for a new Start.
- Width rules:
  - Remaining is AW bits and decrements by 2 or 1 only; no underflow, because 1 is subtracted only when Remaining==1.
  - Timer width is clog2(max(HOLD,GAP)), minimum 1.

Decomposition:
- Shared package (coin_pkg) holds:
  - Coin code constants COIN_NONE=2'b00, COIN_HALF=2'b01, COIN_ONE=2'b10, COIN_RSVD=2'b11.
  - Coin values in half-units: 1 for COIN_HALF, 2 for COIN_ONE.
  - The state enum IDLE/DRIVE/GAP.
- The same package constants are used by the vending-machine FSM.
- One natural sub-module: coin_frame_timer, a loadable down-counter with terminal-count output, used for both HOLD and GAP.

Test Plan:
- Amount=5, Start at E0 (HOLD=2, GAP=1) -> D_out=10 after E0,E1; 00 after E2; 10 after E3,E4; 00 after E5; 01 after E6,E7; 00 after E8; Done=1 only after E9; Busy=1 after E0..E8.
- Amount=0 with Start -> Done=1 for one cycle after E0; Busy and D_out stay 0.
- Amount=1 -> 01 after E0,E1; 00 after E2; Done after E3. Amount=15 -> seven 10 coins, then one 01; Done after E24.
- Abort asserted with D_out=10 at the second coin -> D_out=00 and Busy=0 on the next edge, no Done. A following Start with Amount=2 produces a single 10 coin normally.
- Start pulses while Busy, and Start+Abort together in IDLE -> both ignored: the sequence is unchanged and no new sequence begins.
- Reset=0 asynchronously mid-GAP -> all outputs 0 before the next edge. Reset release, then Start with Amount=3 -> sequence 10, 00, 01, 00, then Done.

Source files
------------

// File: rtl/coin_pkg.sv
// Coin-code encoding, coin values and dispenser state set shared with the vending FSM.
package coin_pkg;

    localparam int unsigned COIN_W = 2;

    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_HALF = 2'b01;
    localparam logic [COIN_W-1:0] COIN_ONE  = 2'b10;
    localparam logic [COIN_W-1:0] COIN_RSVD = 2'b11;

    // Coin values in half-units
    localparam logic [1:0] VAL_HALF = 2'd1;
    localparam logic [1:0] VAL_ONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_e;

    // Value in half-units carried by a coin code; NONE/RSVD carry nothing
    function automatic logic [1:0] coin_value(input logic [COIN_W-1:0] code);
        logic [1:0] v;
        v = 2'd0;
        if (code == COIN_ONE) begin
            v = VAL_ONE;
        end else if (code == COIN_HALF) begin
            v = VAL_HALF;
        end
        return v;
    endfunction

endpackage

// File: rtl/coin_frame_timer.sv
// Loadable down-counter; terminal count when the count reaches zero.
module coin_frame_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/coin_dispenser.sv
// Emits an amount (in half-units) as a greedy, timed sequence of coin codes.
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int unsigned AW   = 4,
    parameter int unsigned HOLD = 2,
    parameter int unsigned GAP  = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [AW-1:0]     Amount,
    input  logic              Abort,
    output logic [COIN_W-1:0] D_out,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned MAX_HG = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned TW     = (MAX_HG > 1) ? $clog2(MAX_HG) : 1;
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP - 1);

    coin_state_e       state_q, state_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [COIN_W-1:0] dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_dec;
    logic              tmr_tc_c;

    // Largest coin that still fits in the given amount (amount must be non-zero)
    function automatic logic [COIN_W-1:0] pick_coin(input logic [AW-1:0] v);
        return (v >= AW'(2)) ? COIN_ONE : COIN_HALF;
    endfunction

    coin_frame_timer #(
        .W (TW)
    ) u_timer (
        .clk        (Clk),
        .rst_n      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .tc_c_o     (tmr_tc_c)
    );

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dout_q  <= COIN_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic; Abort overrides everything
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        if (Abort) begin
            state_d  = ST_IDLE;
            rem_d    = '0;
            dout_d   = COIN_NONE;
            busy_d   = 1'b0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (Amount != '0) begin
                            dout_d   = pick_coin(Amount);
                            rem_d    = Amount - AW'(coin_value(pick_coin(Amount)));
                            busy_d   = 1'b1;
                            state_d  = ST_DRIVE;
                            tmr_load = 1'b1;
                            tmr_val  = HOLD_LD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (tmr_tc_c) begin
                        dout_d   = COIN_NONE;
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_tc_c) begin
                        if (rem_q == '0) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            dout_d   = pick_coin(rem_q);
                            rem_d    = rem_q - AW'(coin_value(pick_coin(rem_q)));
                            state_d  = ST_DRIVE;
                            tmr_load = 1'b1;
                            tmr_val  = HOLD_LD;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    dout_d  = COIN_NONE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign D_out = dout_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser with HOLD=2, GAP=1, AW=4.
module tb_coin_dispenser;

    localparam int unsigned AW = 4;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] Amount;
    logic          Abort;
    logic [1:0]    D_out;
    logic          Busy;
    logic          Done;

    int unsigned n_checks;
    int unsigned n_pass;

    coin_dispenser #(
        .AW   (AW),
        .HOLD (2),
        .GAP  (1)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Amount (Amount),
        .Abort  (Abort),
        .D_out  (D_out),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] d, input logic b, input logic dn);
        check({tag, "_dout"}, 8'(D_out), 8'(d));
        check({tag, "_busy"}, 8'(Busy), 8'(b));
        check({tag, "_done"}, 8'(Done), 8'(dn));
    endtask

    // Start a sequence and compare D_out after every edge against the expected codes;
    // with noise set, Start stays high (Amount=15) while busy and must be ignored
    task automatic run_seq(input string tag, input logic [AW-1:0] amt,
                           input logic [1:0] exp_q[$], input logic noise);
        Start  = 1'b1;
        Amount = amt;
        tick();
        Start  = noise;
        Amount = noise ? 4'd15 : amt;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_outs(tag, exp_q[i], 1'b1, 1'b0);
            if (i == exp_q.size() - 1) Start = 1'b0;
            tick();
        end
        check_outs({tag, "_end"}, 2'b00, 1'b0, 1'b1);
        tick();
        check_outs({tag, "_idle"}, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] q5[$];
        logic [1:0] q1[$];
        logic [1:0] q2[$];
        logic [1:0] q3[$];
        logic [1:0] q15[$];

        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b0;
        Start    = 1'b0;
        Amount   = '0;
        Abort    = 1'b0;

        q5 = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        q1 = '{2'b01, 2'b01, 2'b00};
        q2 = '{2'b10, 2'b10, 2'b00};
        q3 = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        q15 = {};
        for (int c = 0; c < 7; c++) q15 = {q15, 2'b10, 2'b10, 2'b00};
        q15 = {q15, 2'b01, 2'b01, 2'b00};

        #3;
        check_outs("reset", 2'b00, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        check_outs("post_reset", 2'b00, 1'b0, 1'b0);

        // Main greedy sequences
        run_seq("amt5", 4'd5, q5, 1'b0);
        run_seq("amt1", 4'd1, q1, 1'b0);
        run_seq("amt15", 4'd15, q15, 1'b0);

        // Zero amount: single Done pulse, no coin
        Start  = 1'b1;
        Amount = 4'd0;
        tick();
        Start  = 1'b0;
        check_outs("amt0", 2'b00, 1'b0, 1'b1);
        tick();
        check_outs("amt0_after", 2'b00, 1'b0, 1'b0);

        // Abort during the second coin
        Start  = 1'b1;
        Amount = 4'd5;
        tick();
        Start  = 1'b0;
        tick();
        tick();
        tick();
        check_outs("abort_pre", 2'b10, 1'b1, 1'b0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check_outs("abort", 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs("abort_quiet", 2'b00, 1'b0, 1'b0);
        end
        run_seq("amt2", 4'd2, q2, 1'b0);

        // Start while busy is ignored
        run_seq("busy_start", 4'd3, q3, 1'b1);

        // Start together with Abort in IDLE is ignored
        Start  = 1'b1;
        Abort  = 1'b1;
        Amount = 4'd5;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        check_outs("start_abort", 2'b00, 1'b0, 1'b0);
        tick();
        check_outs("start_abort_2", 2'b00, 1'b0, 1'b0);

        // Start in the same cycle as Done is accepted
        Start  = 1'b1;
        Amount = 4'd2;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check_outs("chain_done", 2'b00, 1'b0, 1'b1);
        Start  = 1'b1;
        Amount = 4'd1;
        tick();
        Start = 1'b0;
        check_outs("chain_start", 2'b01, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_outs("chain_end", 2'b00, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-DRIVE clears the coin code at once
        Start  = 1'b1;
        Amount = 4'd1;
        tick();
        Start = 1'b0;
        check("rst_drive_pre", 8'(D_out), 8'h01);
        #2 Reset = 1'b0;
        #1;
        check_outs("rst_drive", 2'b00, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();

        // Asynchronous reset mid-GAP, then a clean restart
        Start  = 1'b1;
        Amount = 4'd3;
        tick();
        Start = 1'b0;
        tick();
        tick();
        check_outs("rst_gap_pre", 2'b00, 1'b1, 1'b0);
        #2 Reset = 1'b0;
        #1;
        check_outs("rst_gap", 2'b00, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        tick();
        check_outs("rst_wait", 2'b00, 1'b0, 1'b0);
        run_seq("amt3", 4'd3, q3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
